// File: rtl/game_pkg.sv
// Shared game constants: screen bounds, spawn point, motion steps and player FSM encoding.
package game_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ARITH_W   = 11;
    localparam int unsigned BTN_W     = 4;

    localparam int unsigned H_START   = 40;
    localparam int unsigned V_START   = 240;
    localparam int unsigned STEP      = 4;
    localparam int unsigned H_MIN     = 20;
    localparam int unsigned H_GOAL    = 600;
    localparam int unsigned V_MIN     = 20;
    localparam int unsigned V_MAX     = 460;
    localparam int unsigned LVL_MAX   = 99;
    localparam int unsigned GRAVITY   = 2;
    localparam int unsigned HALF_SIZE = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_PLAY  = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    // Saturate a signed intermediate coordinate into [lo, hi].
    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic signed [ARITH_W-1:0] val,
        input int unsigned               lo,
        input int unsigned               hi
    );
        logic signed [ARITH_W-1:0] lo_s;
        logic signed [ARITH_W-1:0] hi_s;
        lo_s = $signed(ARITH_W'(lo));
        hi_s = $signed(ARITH_W'(hi));
        if (val < lo_s) begin
            return COORD_W'(lo);
        end
        if (val > hi_s) begin
            return COORD_W'(hi);
        end
        return COORD_W'(val);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the raw button levels.
module btn_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player motion and level controller feeding the collision/score stage.
// Optional feature: define PLAYER_GRAVITY_EN to add a constant downward drift in PLAY.
module player_ctrl
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               move_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               reset_player,
    output logic [COORD_W-1:0] player_h,
    output logic [COORD_W-1:0] player_v,
    output logic [COORD_W-1:0] level,
    output logic               level_up
);

    logic [BTN_W-1:0] btn_s;
    logic             up_s;
    logic             down_s;
    logic             left_s;
    logic             right_s;
    state_t           state;

    logic signed [ARITH_W-1:0] dh;
    logic signed [ARITH_W-1:0] dv;
    logic signed [ARITH_W-1:0] h_sum;
    logic signed [ARITH_W-1:0] v_sum;
    logic [COORD_W-1:0]        h_next;
    logic [COORD_W-1:0]        v_next;

    btn_sync #(
        .WIDTH (BTN_W)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({btn_up, btn_down, btn_left, btn_right}),
        .dout  (btn_s)
    );

    assign up_s    = btn_s[3];
    assign down_s  = btn_s[2];
    assign left_s  = btn_s[1];
    assign right_s = btn_s[0];

    // Candidate position for a PLAY tick: signed step, optional gravity, clamp to screen bounds.
    always_comb begin
        dh = '0;
        dv = '0;
        if (right_s && !left_s) begin
            dh = $signed(ARITH_W'(STEP));
        end else if (left_s && !right_s) begin
            dh = -$signed(ARITH_W'(STEP));
        end
        if (up_s && !down_s) begin
            dv = -$signed(ARITH_W'(STEP));
        end else if (down_s && !up_s) begin
            dv = $signed(ARITH_W'(STEP));
        end
`ifdef PLAYER_GRAVITY_EN
        // Gravity yields only to an effective upward move; cancelled up+down still drifts.
        if (!(up_s && !down_s)) begin
            dv = dv + $signed(ARITH_W'(GRAVITY));
        end
`endif
        h_sum  = $signed({1'b0, player_h}) + dh;
        v_sum  = $signed({1'b0, player_v}) + dv;
        h_next = clamp_coord(h_sum, H_MIN, H_GOAL);
        v_next = clamp_coord(v_sum, V_MIN, V_MAX);
    end

    // Game FSM with registered position, level and level-up pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            player_h <= COORD_W'(H_START);
            player_v <= COORD_W'(V_START);
            level    <= COORD_W'(1);
            level_up <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (reset_player && (state != ST_IDLE)) begin
                // Collision request wins over motion and goal detection.
                state    <= ST_SPAWN;
                player_h <= COORD_W'(H_START);
                player_v <= COORD_W'(V_START);
            end else begin
                case (state)
                    ST_IDLE: begin
                        player_h <= COORD_W'(H_START);
                        player_v <= COORD_W'(V_START);
                        if (move_tick && (|btn_s)) begin
                            state <= ST_PLAY;
                        end
                    end
                    ST_SPAWN: begin
                        player_h <= COORD_W'(H_START);
                        player_v <= COORD_W'(V_START);
                        if (move_tick) begin
                            state <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (move_tick) begin
                            player_h <= h_next;
                            player_v <= v_next;
                            if (h_next == COORD_W'(H_GOAL)) begin
                                state <= ST_WIN;
                            end
                        end
                    end
                    ST_WIN: begin
                        if (level >= COORD_W'(LVL_MAX)) begin
                            level <= COORD_W'(LVL_MAX);
                        end else begin
                            level <= level + COORD_W'(1);
                        end
                        level_up <= 1'b1;
                        player_h <= COORD_W'(H_START);
                        player_v <= COORD_W'(V_START);
                        state    <= ST_SPAWN;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed scoreboard bench for player_ctrl; gravity build runs the drift scenario instead.
module tb_player_ctrl;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       move_tick    = 1'b0;
    logic       btn_up       = 1'b0;
    logic       btn_down     = 1'b0;
    logic       btn_left     = 1'b0;
    logic       btn_right    = 1'b0;
    logic       reset_player = 1'b0;
    logic [9:0] player_h;
    logic [9:0] player_v;
    logic [9:0] level;
    logic       level_up;

    typedef struct {
        string tag;
        int    h;
        int    v;
        int    lvl;
        int    up;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    player_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .move_tick    (move_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .reset_player (reset_player),
        .player_h     (player_h),
        .player_v     (player_v),
        .level        (level),
        .level_up     (level_up)
    );

    always #5 clk = ~clk;

    task automatic sb_push(input string tag, input int h, input int v, input int lvl, input int up);
        exp_t e;
        e.tag = tag;
        e.h   = h;
        e.v   = v;
        e.lvl = lvl;
        e.up  = up;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (player_h === 10'(e.h)) else begin
            n_bad++;
            $error("FAIL %s player_h observed=%0d expected=%0d", e.tag, player_h, e.h);
        end
        n_cmp++;
        assert (player_v === 10'(e.v)) else begin
            n_bad++;
            $error("FAIL %s player_v observed=%0d expected=%0d", e.tag, player_v, e.v);
        end
        n_cmp++;
        assert (level === 10'(e.lvl)) else begin
            n_bad++;
            $error("FAIL %s level observed=%0d expected=%0d", e.tag, level, e.lvl);
        end
        n_cmp++;
        assert (level_up === 1'(e.up)) else begin
            n_bad++;
            $error("FAIL %s level_up observed=%0b expected=%0d", e.tag, level_up, e.up);
        end
    endtask

    task automatic tick();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Lets button changes clear the two-flop synchroniser.
    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        sb_push("reset", 40, 240, 1, 0);
        sb_check();
        reset = 1'b0;

`ifdef PLAYER_GRAVITY_EN
        btn_left = 1'b1;
        settle();
        sb_push("g_leave_idle", 40, 240, 1, 0);
        tick();
        sb_check();
        btn_left = 1'b0;
        settle();
        sb_push("g_first_drift", 40, 242, 1, 0);
        tick();
        sb_check();
        ticks(9);
        sb_push("g_ten_ticks", 40, 260, 1, 0);
        sb_check();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        settle();
        sb_push("g_opposing_1", 40, 262, 1, 0);
        tick();
        sb_check();
        sb_push("g_opposing_2", 40, 264, 1, 0);
        tick();
        sb_check();
        btn_down = 1'b0;
        settle();
        sb_push("g_up_no_gravity", 40, 260, 1, 0);
        tick();
        sb_check();
`else
        // Leave IDLE, then four moving ticks to the right.
        btn_right = 1'b1;
        settle();
        sb_push("t1_leave_idle", 40, 240, 1, 0);
        tick();
        sb_check();
        for (int i = 1; i <= 4; i++) begin
            sb_push("t1_right", 40 + 4 * i, 240, 1, 0);
            tick();
            sb_check();
        end
        repeat (3) @(negedge clk);
        sb_push("t1_hold_no_tick", 56, 240, 1, 0);
        sb_check();

        // Top edge clamp without wrap.
        btn_right = 1'b0;
        btn_up    = 1'b1;
        settle();
        ticks(54);
        sb_push("t2_v24", 56, 24, 1, 0);
        sb_check();
        for (int i = 0; i < 3; i++) begin
            sb_push("t2_top_clamp", 56, 20, 1, 0);
            tick();
            sb_check();
        end

        // Left edge clamp.
        btn_up   = 1'b0;
        btn_left = 1'b1;
        settle();
        ticks(9);
        sb_push("t2_h20", 20, 20, 1, 0);
        sb_check();
        sb_push("t2_left_clamp", 20, 20, 1, 0);
        tick();
        sb_check();

        // Opposing horizontal buttons cancel while down still moves.
        btn_right = 1'b1;
        btn_down  = 1'b1;
        settle();
        sb_push("t2_opposing_h", 20, 24, 1, 0);
        tick();
        sb_check();

        // Bottom edge clamp.
        btn_left  = 1'b0;
        btn_right = 1'b0;
        settle();
        ticks(108);
        sb_push("t2_v456", 20, 456, 1, 0);
        sb_check();
        sb_push("t2_v460", 20, 460, 1, 0);
        tick();
        sb_check();
        sb_push("t2_bottom_clamp", 20, 460, 1, 0);
        tick();
        sb_check();

        // Goal crossing and win sequence.
        btn_down  = 1'b0;
        btn_right = 1'b1;
        settle();
        ticks(144);
        sb_push("t3_h596", 596, 460, 1, 0);
        sb_check();
        sb_push("t3_goal", 600, 460, 1, 0);
        tick();
        sb_check();
        sb_push("t3_win_pulse", 40, 240, 2, 1);
        @(negedge clk);
        sb_check();
        sb_push("t3_pulse_end", 40, 240, 2, 0);
        @(negedge clk);
        sb_check();
        sb_push("t3_spawn_exit", 40, 240, 2, 0);
        tick();
        sb_check();
        sb_push("t3_resume", 44, 240, 2, 0);
        tick();
        sb_check();

        // reset_player for two clocks mid-screen.
        ticks(64);
        sb_push("t4_h300", 300, 240, 2, 0);
        sb_check();
        reset_player = 1'b1;
        sb_push("t4_rp_edge1", 40, 240, 2, 0);
        @(negedge clk);
        sb_check();
        sb_push("t4_rp_edge2", 40, 240, 2, 0);
        @(negedge clk);
        sb_check();
        reset_player = 1'b0;
        repeat (2) @(negedge clk);
        sb_push("t4_spawn_hold", 40, 240, 2, 0);
        sb_check();
        sb_push("t4_spawn_exit", 40, 240, 2, 0);
        tick();
        sb_check();
        sb_push("t4_resume", 44, 240, 2, 0);
        tick();
        sb_check();

        // reset_player coincident with goal crossing.
        ticks(138);
        sb_push("t5_h596", 596, 240, 2, 0);
        sb_check();
        reset_player = 1'b1;
        sb_push("t5_rp_at_goal", 40, 240, 2, 0);
        tick();
        reset_player = 1'b0;
        sb_check();
        sb_push("t5_no_level_up", 40, 240, 2, 0);
        @(negedge clk);
        sb_check();

        // Win repeatedly up to the level ceiling.
        for (int w = 0; w < 97; w++) begin
            tick();
            ticks(140);
            repeat (2) @(negedge clk);
        end
        sb_push("sat_level99", 40, 240, 99, 0);
        sb_check();
        tick();
        ticks(140);
        sb_push("sat_goal", 600, 240, 99, 0);
        sb_check();
        sb_push("sat_pulse_hold", 40, 240, 99, 1);
        @(negedge clk);
        sb_check();

        // Asynchronous reset mid-move.
        tick();
        ticks(5);
        sb_push("mid_move", 60, 240, 99, 0);
        sb_check();
        reset = 1'b1;
        #1;
        sb_push("async_reset", 40, 240, 1, 0);
        sb_check();
        @(negedge clk);
        reset = 1'b0;
        btn_right = 1'b0;
        @(negedge clk);
        sb_push("after_reset", 40, 240, 1, 0);
        sb_check();
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
